// File: rtl/armleocpu_fetch.sv
// armleocpu_fetch: instruction fetch stage that owns the PC, issues one cache request at a time and hands packets to decode
module armleocpu_fetch #(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_2000,
  parameter int          F2E_TYPE_WIDTH = 1,
  parameter int          D2F_CMD_WIDTH  = 2,
  parameter logic [31:0] NOP_INSTR      = 32'h0000_0013
) (
  input  logic                      clk,
  input  logic                      rst_n,
  output logic [1:0]                c_cmd,
  output logic [31:0]               c_address,
  input  logic                      c_done,
  input  logic [3:0]                c_response,
  input  logic [31:0]               c_load_data,
  input  logic                      interrupt_pending,
  output logic                      f2d_valid,
  output logic [F2E_TYPE_WIDTH-1:0] f2d_type,
  output logic [31:0]               f2d_instr,
  output logic [31:0]               f2d_pc,
  output logic [3:0]                f2d_resp,
  input  logic                      d2f_ready,
  input  logic [D2F_CMD_WIDTH-1:0]  d2f_cmd,
  input  logic [31:0]               d2f_branchtarget
);
  localparam logic [D2F_CMD_WIDTH-1:0]  CMD_NONE   = D2F_CMD_WIDTH'(0);
  localparam logic [D2F_CMD_WIDTH-1:0]  CMD_FLUSH  = D2F_CMD_WIDTH'(2);
  localparam logic [F2E_TYPE_WIDTH-1:0] TYPE_INSTR = F2E_TYPE_WIDTH'(0);
  localparam logic [F2E_TYPE_WIDTH-1:0] TYPE_IRQ   = F2E_TYPE_WIDTH'(1);
  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_FLUSH} state_t;
  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_rp;
  logic        r_rp_flush;
  logic [31:0] r_rp_target;
  logic        w_redirect;
  logic        w_is_flush;
  logic [31:0] w_pc_next;
  assign w_redirect = d2f_ready && (d2f_cmd != CMD_NONE);
  assign w_is_flush = d2f_cmd == CMD_FLUSH;
  assign w_pc_next  = r_pc + 32'd4;
  assign c_address  = r_pc;
  // Cache command follows state; held at NONE while reset is asserted
  always_comb c_cmd = !rst_n ? 2'd0 : (r_state == S_FETCH) ? 2'd1 : (r_state == S_FLUSH) ? 2'd2 : 2'd0;
  // PC, packet register and pending-redirect bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_VECTOR;
      r_rp        <= 1'b0;
      r_rp_flush  <= 1'b0;
      r_rp_target <= 32'd0;
      f2d_valid   <= 1'b0;
      f2d_type    <= TYPE_INSTR;
      f2d_instr   <= 32'd0;
      f2d_pc      <= 32'd0;
      f2d_resp    <= 4'd0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (c_done) begin
            if (w_redirect) begin
              r_pc    <= d2f_branchtarget;
              r_state <= w_is_flush ? S_FLUSH : S_FETCH;
              r_rp    <= 1'b0;
            end else if (r_rp) begin
              r_pc    <= r_rp_target;
              r_state <= r_rp_flush ? S_FLUSH : S_FETCH;
              r_rp    <= 1'b0;
            end else begin
              f2d_valid <= 1'b1;
              f2d_type  <= TYPE_INSTR;
              f2d_instr <= c_load_data;
              f2d_pc    <= r_pc;
              f2d_resp  <= c_response;
              r_state   <= S_HOLD;
            end
          end else if (w_redirect) begin
            r_rp        <= 1'b1;
            r_rp_flush  <= w_is_flush;
            r_rp_target <= d2f_branchtarget;
          end
        end
        S_HOLD: begin
          if (d2f_ready) begin
            f2d_valid <= 1'b0;
            if (d2f_cmd == CMD_NONE) begin
              r_pc <= w_pc_next;
              if (interrupt_pending) begin
                f2d_valid <= 1'b1;
                f2d_type  <= TYPE_IRQ;
                f2d_instr <= NOP_INSTR;
                f2d_pc    <= w_pc_next;
                f2d_resp  <= 4'd0;
              end else begin
                r_state <= S_FETCH;
              end
            end else begin
              r_pc    <= d2f_branchtarget;
              r_state <= w_is_flush ? S_FLUSH : S_FETCH;
            end
          end
        end
        S_FLUSH: if (c_done) r_state <= S_FETCH;
        default: r_state <= S_FETCH;
      endcase
    end
  end
endmodule

// File: tb/tb_armleocpu_fetch.sv
// tb_armleocpu_fetch: directed table of per-cycle vectors plus a back-to-back throughput sequence
module tb_armleocpu_fetch;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  c_cmd;
  logic [31:0] c_address;
  logic        c_done = 1'b0;
  logic [3:0]  c_response = 4'd0;
  logic [31:0] c_load_data = 32'd0;
  logic        interrupt_pending = 1'b0;
  logic        f2d_valid;
  logic [0:0]  f2d_type;
  logic [31:0] f2d_instr;
  logic [31:0] f2d_pc;
  logic [3:0]  f2d_resp;
  logic        d2f_ready = 1'b0;
  logic [1:0]  d2f_cmd = 2'd0;
  logic [31:0] d2f_branchtarget = 32'd0;
  int          n_pass = 0;
  int          n_total = 0;

  armleocpu_fetch dut (
    .clk(clk), .rst_n(rst_n), .c_cmd(c_cmd), .c_address(c_address), .c_done(c_done),
    .c_response(c_response), .c_load_data(c_load_data), .interrupt_pending(interrupt_pending),
    .f2d_valid(f2d_valid), .f2d_type(f2d_type), .f2d_instr(f2d_instr), .f2d_pc(f2d_pc),
    .f2d_resp(f2d_resp), .d2f_ready(d2f_ready), .d2f_cmd(d2f_cmd), .d2f_branchtarget(d2f_branchtarget)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        done;
    logic [3:0]  resp;
    logic [31:0] data;
    logic        irq;
    logic        rdy;
    logic [1:0]  cmd;
    logic [31:0] tgt;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic        e_v;
    logic        e_ty;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    logic [3:0]  e_rsp;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic r, logic d, logic [3:0] rs, logic [31:0] dat, logic irq, logic rdy,
                              logic [1:0] cmd, logic [31:0] tgt, logic [1:0] ec, logic [31:0] ea,
                              logic ev, logic ety, logic [31:0] ei, logic [31:0] ep, logic [3:0] er);
    vec_t v;
    v.rst_n = r; v.done = d; v.resp = rs; v.data = dat; v.irq = irq; v.rdy = rdy; v.cmd = cmd; v.tgt = tgt;
    v.e_cmd = ec; v.e_addr = ea; v.e_v = ev; v.e_ty = ety; v.e_ins = ei; v.e_pc = ep; v.e_rsp = er;
    return v;
  endfunction

  task automatic check(input string name, input logic [103:0] act, input logic [103:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          n_deliv;
    //            rst d  rsp dat          irq rdy cmd tgt            | ccmd addr          v  ty ins           pc            rsp
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 32'h0000_2000, 0, 0, 32'h0,        32'h0,        0));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h0000_2000, 0, 0, 32'h0,        32'h0,        0));
    vt.push_back(mk(1, 1, 0, 32'h0050_0093,0, 0, 0, 32'h0,         1, 32'h0000_2000, 0, 0, 32'h0,        32'h0,        0));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 32'h0000_2000, 1, 0, 32'h0050_0093,32'h0000_2000,0));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 32'h0000_2000, 1, 0, 32'h0050_0093,32'h0000_2000,0));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 32'h0000_2000, 1, 0, 32'h0050_0093,32'h0000_2000,0));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h0,         0, 32'h0000_2000, 1, 0, 32'h0050_0093,32'h0000_2000,0));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h0000_2004, 0, 0, 32'h0050_0093,32'h0000_2000,0));
    vt.push_back(mk(1, 1, 5, 32'h0010_0113,0, 0, 0, 32'h0,         1, 32'h0000_2004, 0, 0, 32'h0050_0093,32'h0000_2000,0));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1, 32'h8000_0100, 0, 32'h0000_2004, 1, 0, 32'h0010_0113,32'h0000_2004,5));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1, 32'h0000_2008, 1, 32'h8000_0100, 0, 0, 32'h0010_0113,32'h0000_2004,5));
    vt.push_back(mk(1, 1, 0, 32'hDEAD_BEEF,0, 0, 0, 32'h0,         1, 32'h8000_0100, 0, 0, 32'h0010_0113,32'h0000_2004,5));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1, 32'h0000_3000, 1, 32'h0000_2008, 0, 0, 32'h0010_0113,32'h0000_2004,5));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h0000_2008, 0, 0, 32'h0010_0113,32'h0000_2004,5));
    vt.push_back(mk(1, 1, 3, 32'h1111_1111,0, 0, 0, 32'h0,         1, 32'h0000_2008, 0, 0, 32'h0010_0113,32'h0000_2004,5));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 1, 2, 32'h0000_5000, 1, 32'h0000_3000, 0, 0, 32'h0010_0113,32'h0000_2004,5));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 1, 2, 32'h0000_200C, 1, 32'h0000_3000, 0, 0, 32'h0010_0113,32'h0000_2004,5));
    vt.push_back(mk(1, 1, 0, 32'h2222_2222,0, 0, 0, 32'h0,         1, 32'h0000_3000, 0, 0, 32'h0010_0113,32'h0000_2004,5));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,         2, 32'h0000_200C, 0, 0, 32'h0010_0113,32'h0000_2004,5));
    vt.push_back(mk(1, 1, 7, 32'h3333_3333,0, 0, 0, 32'h0,         2, 32'h0000_200C, 0, 0, 32'h0010_0113,32'h0000_2004,5));
    vt.push_back(mk(1, 1, 0, 32'h00A0_0093,0, 0, 0, 32'h0,         1, 32'h0000_200C, 0, 0, 32'h0010_0113,32'h0000_2004,5));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 1, 2, 32'h0000_2010, 0, 32'h0000_200C, 1, 0, 32'h00A0_0093,32'h0000_200C,0));
    vt.push_back(mk(1, 1, 0, 32'h0,        0, 0, 0, 32'h0,         2, 32'h0000_2010, 0, 0, 32'h00A0_0093,32'h0000_200C,0));
    vt.push_back(mk(1, 1, 0, 32'h0020_8133,0, 0, 0, 32'h0,         1, 32'h0000_2010, 0, 0, 32'h00A0_0093,32'h0000_200C,0));
    vt.push_back(mk(1, 0, 0, 32'h0,        1, 1, 0, 32'h0,         0, 32'h0000_2010, 1, 0, 32'h0020_8133,32'h0000_2010,0));
    vt.push_back(mk(1, 0, 0, 32'h0,        1, 0, 0, 32'h0,         0, 32'h0000_2014, 1, 1, 32'h0000_0013,32'h0000_2014,0));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 1, 1, 32'hFFFF_FFFC, 0, 32'h0000_2014, 1, 1, 32'h0000_0013,32'h0000_2014,0));
    vt.push_back(mk(1, 1, 0, 32'h0000_0073,0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 0, 1, 32'h0000_0013,32'h0000_2014,0));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 0, 32'h0000_0073,32'hFFFF_FFFC,0));
    vt.push_back(mk(1, 1, 0, 32'h4444_4444,0, 1, 1, 32'h0000_4000, 1, 32'h0000_0000, 0, 0, 32'h0000_0073,32'hFFFF_FFFC,0));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 1, 0, 32'h0,         1, 32'h0000_4000, 0, 0, 32'h0000_0073,32'hFFFF_FFFC,0));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h0000_4000, 0, 0, 32'h0000_0073,32'hFFFF_FFFC,0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 32'h0000_2000, 0, 0, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 32'h0000_2000, 0, 0, 32'h0,        32'h0,        0));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,         1, 32'h0000_2000, 0, 0, 32'h0,        32'h0,        0));
    vt.push_back(mk(1, 1, 0, 32'h0050_0093,0, 0, 0, 32'h0,         1, 32'h0000_2000, 0, 0, 32'h0,        32'h0,        0));
    vt.push_back(mk(1, 0, 0, 32'h0,        0, 0, 0, 32'h0,         0, 32'h0000_2000, 1, 0, 32'h0050_0093,32'h0000_2000,0));
    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      rst_n = vt[i].rst_n; c_done = vt[i].done; c_response = vt[i].resp; c_load_data = vt[i].data;
      interrupt_pending = vt[i].irq; d2f_ready = vt[i].rdy; d2f_cmd = vt[i].cmd; d2f_branchtarget = vt[i].tgt;
      #1;
      check($sformatf("vec%0d", i),
            {c_cmd, c_address, f2d_valid, f2d_type, f2d_instr, f2d_pc, f2d_resp},
            {vt[i].e_cmd, vt[i].e_addr, vt[i].e_v, vt[i].e_ty, vt[i].e_ins, vt[i].e_pc, vt[i].e_rsp});
    end
    // zero-wait cache and always-ready decode: one packet every two cycles, sequential PCs
    exp_pc = 32'h0000_2000;
    n_deliv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      c_done = (c_cmd == 2'd1); c_load_data = c_address ^ 32'hA5A5_0000; c_response = 4'd0;
      interrupt_pending = 1'b0; d2f_ready = 1'b1; d2f_cmd = 2'd0; d2f_branchtarget = 32'd0;
      #1;
      if (f2d_valid) begin
        check($sformatf("stream%0d", n_deliv), {72'd0, f2d_pc, f2d_instr},
              {72'd0, exp_pc, (exp_pc == 32'h0000_2000) ? 32'h0050_0093 : (exp_pc ^ 32'hA5A5_0000)});
        exp_pc += 32'd4;
        n_deliv++;
      end
    end
    check("stream_count", 104'(n_deliv), 104'd10);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
